gray_updown_counter: RTL and testbench
======================================

// Module: gray_updown_counter
// PURPOSE
//   Parametrised up/down counter keeping binary and Gray-code views of one count.
//   Parallel load accepts either a binary or a Gray value; Gray loads are converted
//   to binary on entry (MSB-down prefix XOR).
//   Used wherever a Gray-coded pointer/position must cross to other logic with a
//   matching binary value, e.g. FIFO pointers and encoder position tracking.
//   Both views and the terminal-count flag are registered and update on the same edge.
// PARAMETERS
//   WIDTH      4   count width in bits (>=2)
//   WRAP       1   1: wrap at max/0 (modulo 2^WIDTH); 0: saturate at max/0
//   RESET_VAL  0   binary count value loaded on reset (must be < 2^WIDTH)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      step enable; one step per clk while high
//   up         in   1      step direction: 1 = increment, 0 = decrement
//   load       in   1      parallel load strobe; overrides en
//   load_gray  in   1      1: load_val is Gray-coded; 0: load_val is binary
//   load_val   in   WIDTH  value to load
//   bin_o      out  WIDTH  registered binary count
//   gray_o     out  WIDTH  registered Gray count, always gray(bin_o) = bin_o ^ (bin_o >> 1)
//   tc_o       out  1      registered terminal-count pulse
// BEHAVIOUR
//   Reset (rst_n low, asynchronous, no clock needed):
//   - bin_o = RESET_VAL, gray_o = gray(RESET_VAL), tc_o = 0.
//   - Outputs hold while rst_n is low.
//   - rst_n release is synchronised to clk upstream.
//   Per rising clk edge, first matching priority applies:
//   1. load=1:
//      - load_gray=0: next = load_val.
//      - load_gray=1: next[WIDTH-1] = load_val[WIDTH-1];
//        next[k] = next[k+1] ^ load_val[k], for k from WIDTH-2 down to 0.
//      - tc_o <= 0. en and up are ignored.
//   2. en=1, up=1:
//      - bin_o < max: next = bin_o + 1, tc_o <= 0.
//      - bin_o = max: tc_o <= 1; next = 0 if WRAP=1, else next = max.
//   3. en=1, up=0:
//      - bin_o > 0: next = bin_o - 1, tc_o <= 0.
//      - bin_o = 0: tc_o <= 1; next = max if WRAP=1, else next = 0.
//   4. Otherwise: hold bin_o and gray_o; tc_o <= 0.
//   - max = 2^WIDTH - 1.
//   - Latency: one clk from strobe to new bin_o/gray_o/tc_o. No combinational path
//     from inputs to outputs.
//   - gray_o is computed from next and registered with bin_o; the two are never
//     inconsistent on any cycle.
//   - Every enabled step, including a WRAP=1 wrap, changes exactly one bit of gray_o.
//     A saturated step (WRAP=0 at limit) changes no bit.
//   - tc_o is high for one cycle per limit step. Back-to-back limit steps with
//     WRAP=0 hold tc_o high on every such cycle.
//   - A direction change takes effect on the same edge; no pipeline to flush.
//   - Arithmetic is modulo 2^WIDTH; no carry-out port.
// TESTING (WIDTH=4, RESET_VAL=0 unless stated)
//   1. Reset: rst_n=0, no clk edge -> bin_o=0000, gray_o=0000, tc_o=0 immediately.
//   2. WRAP=1, en=1, up=1 for 16 clks from 0:
//      - gray_o = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,
//        1010,1011,1001,1000, then 0000 with tc_o=1 on the wrap cycle only.
//      - Exactly one gray bit changes per step.
//   3. load=1, load_gray=1, load_val=1101 -> next clk bin_o=1001, gray_o=1101, tc_o=0.
//      load_gray=0, load_val=1011 -> bin_o=1011, gray_o=1110.
//   4. WRAP=0, at bin_o=0000, en=1, up=0 for 3 clks -> bin_o stays 0000, gray_o stays
//      0000, tc_o=1 all 3 cycles. Then up=1 -> bin_o=0001, tc_o=0.
//   5. Same cycle load=1 (binary 0110) and en=1, up=1 at bin_o=1111
//      -> bin_o=0110, gray_o=0101, tc_o=0 (load wins).
//   6. Counting up at bin_o=0111, pull rst_n low between edges -> outputs go to
//      0000/0000/0 before the next edge. After release, counting resumes from 0000.

Source files
------------

// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - up/down counter with registered binary and Gray views
// Parallel load accepts binary or Gray input; Gray values are decoded before storage.
module gray_updown_counter #(
    parameter int          WIDTH     = 4,
    parameter bit          WRAP      = 1'b1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_tc;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_next;
    logic             w_tc;

    // Binary bit k of a Gray value is the XOR of all Gray bits from the MSB down to k.
    genvar k;
    generate
        for (k = 0; k < WIDTH; k++) begin : g_gray2bin
            assign w_load_bin[k] = ^load_val[WIDTH-1:k];
        end
    endgenerate

    always_comb begin
        w_next = r_bin;
        w_tc   = 1'b0;
        if (load) begin
            w_next = load_gray ? w_load_bin : load_val;
        end else if (en) begin
            if (up) begin
                if (r_bin == MAX_VAL) begin
                    w_tc   = 1'b1;
                    w_next = WRAP ? '0 : MAX_VAL;
                end else begin
                    w_next = r_bin + ONE;
                end
            end else begin
                if (r_bin == '0) begin
                    w_tc   = 1'b1;
                    w_next = WRAP ? MAX_VAL : '0;
                end else begin
                    w_next = r_bin - ONE;
                end
            end
        end
    end

    // Gray is derived from the next binary value so both views land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= RST_BIN;
            r_gray <= RST_BIN ^ (RST_BIN >> 1);
            r_tc   <= 1'b0;
        end else begin
            r_bin  <= w_next;
            r_gray <= w_next ^ (w_next >> 1);
            r_tc   <= w_tc;
        end
    end

    assign bin_o  = r_bin;
    assign gray_o = r_gray;
    assign tc_o   = r_tc;

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb/tb_gray_updown_counter.sv - bench for gray_updown_counter, wrapping and saturating instances
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up, load, load_gray;
    logic [3:0] load_val;
    logic [3:0] bin0, gray0, bin1, gray1;
    logic       tc0, tc1;

    int n_checks = 0;
    int n_fail   = 0;

    int m_bin[2];
    bit m_tc[2];
    bit m_stepped[2];
    bit m_sat[2];

    logic [3:0] gray_tbl [16];

    always #5 clk = ~clk;

    gray_updown_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin_o(bin0), .gray_o(gray0), .tc_o(tc0)
    );

    gray_updown_counter #(.WIDTH(4), .WRAP(1'b0), .RESET_VAL(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin_o(bin1), .gray_o(gray1), .tc_o(tc1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: the binary value whose Gray code equals g.
    function automatic int from_gray(input int g);
        for (int b = 0; b < 16; b++)
            if (to_gray(b) == g) return b;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_bin[i] = 0;
            m_tc[i]  = 1'b0;
        end
    endfunction

    function automatic void model_step(input bit e, input bit u, input bit l, input bit lg, input int v);
        for (int i = 0; i < 2; i++) begin
            bit wrap;
            wrap         = (i == 0);
            m_stepped[i] = e && !l;
            m_sat[i]     = 1'b0;
            m_tc[i]      = 1'b0;
            if (l) begin
                m_bin[i] = lg ? from_gray(v) : v;
            end else if (e) begin
                if (u && m_bin[i] == 15) begin
                    m_tc[i]  = 1'b1;
                    m_sat[i] = !wrap;
                    m_bin[i] = wrap ? 0 : 15;
                end else if (!u && m_bin[i] == 0) begin
                    m_tc[i]  = 1'b1;
                    m_sat[i] = !wrap;
                    m_bin[i] = wrap ? 15 : 0;
                end else begin
                    m_bin[i] = u ? m_bin[i] + 1 : m_bin[i] - 1;
                end
            end
        end
    endfunction

    task automatic check_all();
        check_eq("bin_wrap",  32'(bin0),  32'(m_bin[0]));
        check_eq("gray_wrap", 32'(gray0), 32'(to_gray(m_bin[0])));
        check_eq("tc_wrap",   32'(tc0),   32'(m_tc[0]));
        check_eq("bin_sat",   32'(bin1),  32'(m_bin[1]));
        check_eq("gray_sat",  32'(gray1), 32'(to_gray(m_bin[1])));
        check_eq("tc_sat",    32'(tc1),   32'(m_tc[1]));
    endtask

    // Called at a negedge: drive, let one posedge pass, sample at the following negedge.
    task automatic cycle(input bit e, input bit u, input bit l, input bit lg, input logic [3:0] v);
        logic [3:0] pg0, pg1;
        en = e; up = u; load = l; load_gray = lg; load_val = v;
        pg0 = gray0;
        pg1 = gray1;
        @(posedge clk);
        model_step(e, u, l, lg, int'(v));
        @(negedge clk);
        check_all();
        if (m_stepped[0]) check_eq("gray_step_bits_wrap", 32'($countones(pg0 ^ gray0)), 32'd1);
        if (m_stepped[1]) check_eq("gray_step_bits_sat", 32'($countones(pg1 ^ gray1)),
                                   m_sat[1] ? 32'd0 : 32'd1);
    endtask

    initial begin
        gray_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        en = 0; up = 0; load = 0; load_gray = 0; load_val = '0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Full wrapping count-up against the reference Gray sequence.
        for (int i = 0; i < 16; i++) begin
            check_eq("gray_seq", 32'(gray0), 32'(gray_tbl[i]));
            cycle(1, 1, 0, 0, 4'h0);
        end
        check_eq("wrap_gray", 32'(gray0), 32'd0);
        check_eq("wrap_tc", 32'(tc0), 32'd1);

        // Gray and binary loads.
        cycle(0, 0, 1, 1, 4'b1101);
        check_eq("load_gray_bin", 32'(bin0), 32'b1001);
        cycle(0, 0, 1, 0, 4'b1011);
        check_eq("load_bin_gray", 32'(gray0), 32'b1110);

        // Saturation at zero, then direction change.
        cycle(0, 0, 1, 0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 4'h0);
            check_eq("sat_low_tc", 32'(tc1), 32'd1);
        end
        cycle(1, 1, 0, 0, 4'h0);
        check_eq("sat_resume_bin", 32'(bin1), 32'd1);

        // Load wins over enable at max.
        cycle(0, 0, 1, 0, 4'b1111);
        cycle(1, 1, 1, 0, 4'b0110);
        check_eq("load_prio_gray", 32'(gray0), 32'b0101);

        // Asynchronous reset between edges.
        cycle(0, 0, 1, 0, 4'b0110);
        cycle(1, 1, 0, 0, 4'h0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 1, 0, 0, 4'h0);
        check_eq("resume_bin", 32'(bin0), 32'd1);

        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
